// File: rtl/chunked_add_ctrl.sv
// Multi-cycle WIDTH-bit adder sequencer driving one external CHUNK-bit slice.
// Operands are latched, fed LSB chunk first, and the sum is returned via valid/ready.
module chunked_add_ctrl #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    output logic [CHUNK-1:0] slc_a,
    output logic [CHUNK-1:0] slc_b,
    output logic             slc_cin,
    input  logic [CHUNK-1:0] slc_sum,
    input  logic             slc_cout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             busy
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IW-1:0] LAST = IW'(NCHUNK - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           nxt;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum_q;
    logic             carry_q;
    logic             cout_q;
    logic             ovf_q;
    logic [IW-1:0]    idx;
    logic [CHUNK-1:0] a_ch;
    logic [CHUNK-1:0] b_ch;
    logic             run;
    logic             last;
    logic             accept;

    assign run    = (state == RUN);
    assign last   = run && (idx == LAST);
    assign accept = in_valid && in_ready;

    always_comb begin
        a_ch = '0;
        b_ch = '0;
        for (int i = 0; i < NCHUNK; i++) begin
            if (idx == IW'(i)) begin
                a_ch = a_q[i*CHUNK +: CHUNK];
                b_ch = b_q[i*CHUNK +: CHUNK];
            end
        end
    end

    // Slice inputs are forced quiet outside RUN so the shared slice never toggles idly
    assign slc_a   = run ? a_ch : '0;
    assign slc_b   = run ? b_ch : '0;
    assign slc_cin = run && carry_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= nxt;
        end
    end

    always_comb begin
        nxt       = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) nxt = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (idx == LAST) nxt = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) nxt = IDLE;
            end
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            idx     <= '0;
        end else if (accept) begin
            a_q     <= in_a;
            b_q     <= in_b;
            carry_q <= in_cin;
            idx     <= '0;
            sum_q   <= '0;
        end else if (run) begin
            for (int i = 0; i < NCHUNK; i++) begin
                if (idx == IW'(i)) sum_q[i*CHUNK +: CHUNK] <= slc_sum;
            end
            carry_q <= slc_cout;
            if (last) begin
                cout_q <= slc_cout;
                // Top chunk's sum MSB is the final sign bit
                ovf_q  <= (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                          (slc_sum[CHUNK-1] != a_q[WIDTH-1]);
                idx    <= '0;
            end else begin
                idx <= idx + 1'b1;
            end
        end
    end

    assign out_sum  = sum_q;
    assign out_cout = cout_q;
    assign out_ovf  = ovf_q;

endmodule

// File: tb/tb_chunked_add_ctrl.sv
// Scoreboard bench for chunked_add_ctrl: bench-side slice model,
// full-width arithmetic reference, decoupled result monitor.
module tb_chunked_add_ctrl;

    localparam int W = 32;
    localparam int C = 8;
    localparam int N = W / C;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_cin;
    logic [C-1:0] slc_a;
    logic [C-1:0] slc_b;
    logic         slc_cin;
    logic [C-1:0] slc_sum;
    logic         slc_cout;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_cout;
    logic         out_ovf;
    logic         busy;

    chunked_add_ctrl #(.WIDTH(W), .CHUNK(C)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a     (in_a),
        .in_b     (in_b),
        .in_cin   (in_cin),
        .slc_a    (slc_a),
        .slc_b    (slc_b),
        .slc_cin  (slc_cin),
        .slc_sum  (slc_sum),
        .slc_cout (slc_cout),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_sum  (out_sum),
        .out_cout (out_cout),
        .out_ovf  (out_ovf),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // External slice: plain combinational adder
    always_comb begin
        {slc_cout, slc_sum} = {1'b0, slc_a} + {1'b0, slc_b} + (C + 1)'(slc_cin);
    end

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } res_t;

    res_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic cin);
        res_t       r;
        logic [W:0] t;
        t      = {1'b0, a} + {1'b0, b} + (W + 1)'(cin);
        r.sum  = t[W-1:0];
        r.cout = t[W];
        r.ovf  = (a[W-1] == b[W-1]) && (t[W-1] != a[W-1]);
        return r;
    endfunction

    // Carry into chunk c = bit c*C of the sum of the lower c*C bits
    function automatic logic chunk_cin(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic cin, input int c);
        logic [63:0] m;
        logic [63:0] s;
        m = (64'd1 << (c * C)) - 64'd1;
        s = ({32'd0, a} & m) + ({32'd0, b} & m) + {63'd0, cin};
        return s[c * C];
    endfunction

    initial begin : monitor
        res_t e;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result got %0h want none", out_sum);
                end else begin
                    e = sb.pop_front();
                    chk("out_sum", {32'd0, out_sum}, {32'd0, e.sum});
                    chk("out_cout", {63'd0, out_cout}, {63'd0, e.cout});
                    chk("out_ovf", {63'd0, out_ovf}, {63'd0, e.ovf});
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                        input int hold, input bit abort);
        res_t e;
        int   t;
        e = model(a, b, cin);
        t = 0;
        while (!in_ready && t < 50) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (!in_ready) begin
            chk("in_ready_timeout", 64'd0, 64'd1);
            return;
        end
        out_ready = (hold == 0);
        in_a      = a;
        in_b      = b;
        in_cin    = cin;
        in_valid  = 1'b1;
        @(posedge clk);
        sb.push_back(e);
        #1;
        in_valid = 1'b0;
        in_a     = $urandom;
        in_b     = $urandom;
        in_cin   = 1'($urandom);
        for (int c = 0; c < N; c++) begin
            @(negedge clk);
            if (abort && c == 1) begin
                #1 rst_n = 1'b0;
                #1;
                chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
                chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
                chk("rst_busy", {63'd0, busy}, 64'd0);
                chk("rst_slc_a", {56'd0, slc_a}, 64'd0);
                chk("rst_slc_b", {56'd0, slc_b}, 64'd0);
                chk("rst_slc_cin", {63'd0, slc_cin}, 64'd0);
                void'(sb.pop_back());
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            chk("run_busy", {63'd0, busy}, 64'd1);
            chk("run_out_valid", {63'd0, out_valid}, 64'd0);
            chk("run_slc_a", {56'd0, slc_a}, {56'd0, a[c*C +: C]});
            chk("run_slc_b", {56'd0, slc_b}, {56'd0, b[c*C +: C]});
            chk("run_slc_cin", {63'd0, slc_cin}, {63'd0, chunk_cin(a, b, cin, c)});
        end
        @(negedge clk);
        chk("latency_valid", {63'd0, out_valid}, 64'd1);
        if (hold > 0) begin
            in_valid = 1'b1;
            in_a     = $urandom;
            in_b     = $urandom;
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                chk("hold_valid", {63'd0, out_valid}, 64'd1);
                chk("hold_in_ready", {63'd0, in_ready}, 64'd0);
                chk("hold_busy", {63'd0, busy}, 64'd1);
                chk("hold_sum", {32'd0, out_sum}, {32'd0, e.sum});
            end
            @(posedge clk);
            #1;
            out_ready = 1'b1;
            in_valid  = 1'b0;
        end
        @(posedge clk);
        #1;
        chk("idle_in_ready", {63'd0, in_ready}, 64'd1);
        chk("idle_out_valid", {63'd0, out_valid}, 64'd0);
    endtask

    initial begin : stim
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_cin    = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_in_ready", {63'd0, in_ready}, 64'd1);
        chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
        chk("reset_out_sum", {32'd0, out_sum}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("idle_ready", {63'd0, in_ready}, 64'd1);
            chk("idle_valid", {63'd0, out_valid}, 64'd0);
            chk("idle_busy", {63'd0, busy}, 64'd0);
            chk("idle_slc", {47'd0, slc_a, slc_b, slc_cin}, 64'd0);
            chk("idle_res", {30'd0, out_sum, out_cout, out_ovf}, 64'd0);
        end

        send(32'h0000_00FF, 32'h0000_0001, 1'b0, 0, 1'b0);
        send(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 0, 1'b0);
        send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 0, 1'b0);
        send(32'h8000_0000, 32'h8000_0000, 1'b0, 0, 1'b0);
        send(32'hDEAD_BEEF, 32'h1234_5678, 1'b1, 5, 1'b0);
        send(32'h0000_0001, 32'h0000_0002, 1'b0, 0, 1'b0);
        send(32'hCAFE_F00D, 32'h0F0F_0F0F, 1'b1, 0, 1'b1);
        send(32'h1234_5678, 32'h1111_1111, 1'b0, 0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            send($urandom, $urandom, 1'($urandom), int'($urandom_range(0, 3)), 1'b0);
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
